banked_mem_responder: RTL and testbench
=======================================

// Module: banked_mem_responder
// PURPOSE
//  Main-memory responder on the memory side of the cache controller's mem_rd/mem_wr interface.
//  Four interleaved banks; each accepted access keeps its bank busy for BUSY_CYCLES cycles.
//  Reports per-bank busy, stalls requests to busy banks, and returns read data after a fixed latency.
//  The cache FSM sequences its multi-word fills and writebacks against this timing.
// PARAMETERS
//  ADDR_W       16  byte-address width; word = 16 bits, bank = addr[2:1]
//  MEM_WORDS    8192  storage depth in 16-bit words, indexed by addr[ADDR_W-1:1] mod MEM_WORDS
//  BUSY_CYCLES  4   cycles a bank stays busy after acceptance; legal range 1..7
//  READ_LAT     2   cycles from read acceptance to valid data_out; legal range 1..3
// PORTS
//  clk       in   1        clock, rising edge
//  rst       in   1        reset, asynchronous, active-high
//  addr      in   ADDR_W   byte address of the request
//  data_in   in   16       write data
//  wr        in   1        write request
//  rd        in   1        read request
//  data_out  out  16       read data, valid READ_LAT cycles after read acceptance, held until next read result
//  stall     out  1        combinational: request present and target bank busy; request not accepted
//  busy      out  4        per-bank busy flags, busy[b] for bank b
//  err       out  1        combinational: illegal request this cycle; request not accepted
// BEHAVIOUR
//  Reset: data_out=0, busy=0, all bank counters=0, read pipeline flushed. stall and err follow their inputs.
//  Storage is not cleared by rst; simulation zero-initialises it at time 0.
//  bank = addr[2:1]. req = rd|wr. err = rd&wr (plus odd address, see CONFIGURATION).
//  stall = req & ~err & busy[bank]. Accept in cycle T when req & ~err & ~stall.
//  Per-bank 3-bit down-counter cnt[b]: loaded with BUSY_CYCLES at the edge ending T; decrements each
//    cycle while nonzero. busy[b] = (cnt[b]!=0), so busy[b]=1 during cycles T+1..T+BUSY_CYCLES.
//  Write: mem[idx] <= data_in at the edge ending T. No data_out change.
//  Read: mem[idx] sampled at the edge ending T and shifted through a READ_LAT-deep pipeline with a
//    valid bit; data_out updates at the edge ending T+READ_LAT-1, i.e. new value visible in cycle T+READ_LAT.
//  Read-after-write to the same word returns the written data (bank busy forces >=1 cycle gap).
//  Accesses to different banks are accepted back to back, one per cycle; up to 4 banks busy at once.
//  Pipelined reads complete in order; two reads in flight return in acceptance order.
//  Stalled or erroring requests leave storage, counters and the pipeline unchanged.
//  Reset mid-operation: in-flight reads are dropped (data_out stays 0); busy clears immediately.
//  Requester must hold addr/data_in/rd/wr stable while stall is high; no internal request buffering.
// CONFIGURATION
//  MEM_UNALIGNED_ERR_EN defined: addr[0]=1 with req also raises err; request rejected, no side effects.
//  Not defined: addr[0] ignored; odd address accesses the containing word normally; err = rd&wr only.
// TESTING
//  1 Reset: assert rst mid-read pipeline -> data_out=0, busy=4'b0000 same cycle, no late data after release.
//  2 wr addr=0x0010 data=0xBEEF in T -> busy=4'b0001 for T+1..T+4, 4'b0000 at T+5; rd 0x0010 at T+5 -> data_out=0xBEEF in T+7.
//  3 rd 0x0000 in T, rd 0x0008 in T+1 (same bank 0) -> stall=1 in T+1..T+4, accepted at T+5, data at T+7.
//  4 rd 0x0000,0x0002,0x0004,0x0006 in T..T+3 -> no stall, busy=4'b1111 in T+4, data_out sequence in T+2..T+5 in order.
//  5 rd=wr=1 addr=0x0020 -> err=1, stall=0, busy unchanged, mem[0x0010] unchanged.
//  6 MEM_UNALIGNED_ERR_EN: wr addr=0x0011 -> err=1, no write; undefined: writes word 0x0008, busy[0]=1 next cycle.

Source files
------------

// File: rtl/banked_mem_responder.sv
// banked_mem_responder: four interleaved 16-bit banks with per-bank busy timing and fixed read latency.
// Define MEM_UNALIGNED_ERR_EN to reject odd byte addresses with err.
module banked_mem_responder #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned MEM_WORDS   = 8192,
    parameter int unsigned BUSY_CYCLES = 4,
    parameter int unsigned READ_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       data_in,
    input  logic              wr,
    input  logic              rd,
    output logic [15:0]       data_out,
    output logic              stall,
    output logic [3:0]        busy,
    output logic              err
);
    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [1:0]       bank;
    logic [IDX_W-1:0] idx;
    logic             req;
    logic             acc;
    logic             acc_rd;
    logic             acc_wr;
    logic [2:0]       cnt_q [4];
    logic [2:0]       cnt_d [4];
    logic [15:0]      mem_q [MEM_WORDS];
    logic [15:0]      rd_word;
    logic [15:0]      data_out_q;
    logic [15:0]      data_out_d;
    logic             tail_vld;
    logic [15:0]      tail_dat;

    assign bank    = addr[2:1];
    assign idx     = IDX_W'(addr[ADDR_W-1:1] % MEM_WORDS);
    assign req     = rd | wr;
    assign rd_word = mem_q[idx];

`ifdef MEM_UNALIGNED_ERR_EN
    assign err = (rd & wr) | (req & addr[0]);
`else
    logic unused_addr0;
    assign unused_addr0 = addr[0];
    assign err = rd & wr;
`endif

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            busy[b] = (cnt_q[b] != 3'd0);
        end
    end

    assign stall  = req & ~err & busy[bank];
    assign acc    = req & ~err & ~busy[bank];
    assign acc_rd = acc & rd;
    assign acc_wr = acc & wr;

    // An accepted bank is necessarily idle, so the load never races a decrement.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            cnt_d[b] = cnt_q[b];
            if (acc && (bank == 2'(b))) begin
                cnt_d[b] = 3'(BUSY_CYCLES);
            end else if (cnt_q[b] != 3'd0) begin
                cnt_d[b] = cnt_q[b] - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                cnt_q[b] <= 3'd0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (acc_wr) begin
            mem_q[idx] <= data_in;
        end
    end

    if (READ_LAT == 1) begin : g_direct
        assign tail_vld = acc_rd;
        assign tail_dat = rd_word;
    end else begin : g_pipe
        localparam int unsigned D = READ_LAT - 1;

        logic [D-1:0]       vld_q;
        logic [D-1:0]       vld_d;
        logic [D-1:0][15:0] dat_q;
        logic [D-1:0][15:0] dat_d;

        always_comb begin
            vld_d    = '0;
            dat_d    = '0;
            vld_d[0] = acc_rd;
            dat_d[0] = rd_word;
            for (int i = 1; i < int'(D); i++) begin
                vld_d[i] = vld_q[i-1];
                dat_d[i] = dat_q[i-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        assign tail_vld = vld_q[D-1];
        assign tail_dat = dat_q[D-1];
    end

    assign data_out_d = tail_vld ? tail_dat : data_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= 16'h0000;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_banked_mem_responder.sv
// tb_banked_mem_responder: directed stimulus against a timestamp/queue model of the responder,
// with per-cycle output comparison and hand-computed expectations.
module tb_banked_mem_responder;
    localparam int BUSY = 4;
    localparam int LAT  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    banked_mem_responder #(
        .ADDR_W      (16),
        .MEM_WORDS   (8192),
        .BUSY_CYCLES (BUSY),
        .READ_LAT    (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .wr       (wr),
        .rd       (rd),
        .data_out (data_out),
        .stall    (stall),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a bank is busy while the cycle number is below its free_at stamp;
    // reads wait in a queue stamped with the cycle their data becomes visible.
    typedef struct {
        int          due;
        logic [15:0] d;
    } rd_t;

    int          cyc = 0;
    int          free_at [4] = '{0, 0, 0, 0};
    rd_t         rq [$];
    logic [15:0] shadow [int];
    logic [15:0] exp_dout = 16'h0000;
    int          m_bank;
    int          m_word;
    rd_t         m_head;

    function automatic logic m_err();
        logic e;
        e = rd & wr;
`ifdef MEM_UNALIGNED_ERR_EN
        e = e | ((rd | wr) & addr[0]);
`endif
        return e;
    endfunction

    function automatic logic [15:0] m_mem(input int w);
        if (shadow.exists(w)) return shadow[w];
        return 16'h0000;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_dout = 16'h0000;
            rq.delete();
            for (int b = 0; b < 4; b++) free_at[b] = 0;
        end else begin
            m_bank = int'(addr[2:1]);
            m_word = int'(addr >> 1) % 8192;
            if ((rd | wr) && !m_err() && !(cyc < free_at[m_bank])) begin
                if (wr) shadow[m_word] = data_in;
                if (rd) rq.push_back('{due: cyc + LAT, d: m_mem(m_word)});
                free_at[m_bank] = cyc + BUSY + 1;
            end
            cyc++;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                m_head   = rq.pop_front();
                exp_dout = m_head.d;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [3:0] eb;
        logic       es;
        for (int b = 0; b < 4; b++) eb[b] = (cyc < free_at[b]);
        es = (rd | wr) & ~m_err() & eb[addr[2:1]];
        chk("m_err",   16'(err),   16'(m_err()));
        chk("m_stall", 16'(stall), 16'(es));
        chk("m_busy",  16'(busy),  16'(eb));
        chk("m_dout",  data_out,   exp_dout);
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = 16'h0000;
        data_in = 16'h0000;
    endtask

    task automatic do_acc(input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d);
        int k;
        k       = 0;
        rd      = r;
        wr      = w;
        addr    = a;
        data_in = d;
        @(negedge clk);
        while (stall && k < 20) begin
            nxt();
            @(negedge clk);
            k++;
        end
        chk("acc_wait", 16'(stall), 16'h0000);
        nxt();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [15:0] t4_val [4];
        t4_val = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        idle();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_dout", data_out, 16'h0000);
        chk("rst_busy", 16'(busy), 16'h0000);
        nxt();
        rst = 1'b0;
        nxt();

        do_acc(1'b0, 1'b1, 16'h0000, 16'h1111);
        do_acc(1'b0, 1'b1, 16'h0002, 16'h2222);
        do_acc(1'b0, 1'b1, 16'h0004, 16'h3333);
        do_acc(1'b0, 1'b1, 16'h0006, 16'h4444);
        do_acc(1'b0, 1'b1, 16'h0008, 16'h5555);
        do_acc(1'b0, 1'b1, 16'h0020, 16'h6666);
        repeat (6) nxt();

        // write then read back after the busy window
        rd = 1'b0; wr = 1'b1; addr = 16'h0010; data_in = 16'hBEEF;
        @(negedge clk);
        chk("t2_stall", 16'(stall), 16'h0000);
        nxt();
        idle();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t2_busy", 16'(busy), 16'h0001);
            nxt();
        end
        rd = 1'b1; addr = 16'h0010;
        @(negedge clk);
        chk("t2_free", 16'(busy), 16'h0000);
        chk("t2_rdstall", 16'(stall), 16'h0000);
        nxt();
        idle();
        nxt();
        @(negedge clk);
        chk("t2_rdata", data_out, 16'hBEEF);
        nxt();
        repeat (5) nxt();

        // same-bank back-to-back reads
        rd = 1'b1; addr = 16'h0000;
        @(negedge clk);
        chk("t3_first", 16'(stall), 16'h0000);
        nxt();
        addr = 16'h0008;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t3_stall", 16'(stall), 16'h0001);
            if (i == 2) chk("t3_rd0", data_out, 16'h1111);
            nxt();
        end
        @(negedge clk);
        chk("t3_accept", 16'(stall), 16'h0000);
        nxt();
        idle();
        nxt();
        @(negedge clk);
        chk("t3_rd8", data_out, 16'h5555);
        nxt();
        repeat (5) nxt();

        // four banks back to back
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                rd = 1'b1; wr = 1'b0; addr = 16'(2 * i);
            end else begin
                idle();
            end
            @(negedge clk);
            if (i < 4) chk("t4_stall", 16'(stall), 16'h0000);
            if (i == 4) chk("t4_busy", 16'(busy), 16'h000F);
            if (i >= 2) chk("t4_data", data_out, t4_val[i-2]);
            nxt();
        end
        idle();
        repeat (6) nxt();

        // rd and wr together is rejected
        rd = 1'b1; wr = 1'b1; addr = 16'h0020; data_in = 16'hDEAD;
        @(negedge clk);
        chk("t5_err", 16'(err), 16'h0001);
        chk("t5_stall", 16'(stall), 16'h0000);
        chk("t5_busy", 16'(busy), 16'h0000);
        nxt();
        idle();
        @(negedge clk);
        chk("t5_busy_after", 16'(busy), 16'h0000);
        nxt();
        do_acc(1'b1, 1'b0, 16'h0020, 16'h0000);
        nxt();
        @(negedge clk);
        chk("t5_mem", data_out, 16'h6666);
        nxt();
        repeat (5) nxt();

        // odd address write
        rd = 1'b0; wr = 1'b1; addr = 16'h0011; data_in = 16'h7777;
        @(negedge clk);
`ifdef MEM_UNALIGNED_ERR_EN
        chk("t6_err", 16'(err), 16'h0001);
`else
        chk("t6_err", 16'(err), 16'h0000);
        chk("t6_stall", 16'(stall), 16'h0000);
`endif
        nxt();
        idle();
        @(negedge clk);
`ifdef MEM_UNALIGNED_ERR_EN
        chk("t6_busy", 16'(busy), 16'h0000);
`else
        chk("t6_busy", 16'(busy), 16'h0001);
`endif
        nxt();
        repeat (5) nxt();
        do_acc(1'b1, 1'b0, 16'h0010, 16'h0000);
        nxt();
        @(negedge clk);
`ifdef MEM_UNALIGNED_ERR_EN
        chk("t6_mem", data_out, 16'hBEEF);
`else
        chk("t6_mem", data_out, 16'h7777);
`endif
        nxt();
        repeat (5) nxt();

        // reset with a read in flight
        rd = 1'b1; addr = 16'h0002;
        @(negedge clk);
        nxt();
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("t1_dout", data_out, 16'h0000);
        chk("t1_busy", 16'(busy), 16'h0000);
        nxt();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_nolate", data_out, 16'h0000);
            nxt();
        end
        do_acc(1'b1, 1'b0, 16'h0006, 16'h0000);
        nxt();
        @(negedge clk);
        chk("t1_recover", data_out, 16'h4444);
        nxt();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
